// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and size helpers for the split-access LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE0  = 3'd1,
    ST_ISSUE1  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Number of bytes touched by an access; zero for encodings we do not support.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      F3_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd0;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic is_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: is_legal = 1'b1;
      F3_BU, F3_HU:     is_legal = !we;
      default:          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: positions store data/byte enables across two
// words and merges/extends two read words into a load result.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [31:0] store_lo,
  output logic [31:0] store_hi,
  output logic [7:0]  store_mask,
  output logic [31:0] load_data
);

  logic [31:0] size_mask;
  logic [3:0]  byte_mask;
  logic [63:0] store_wide;
  logic [31:0] merged;

  // Shift the size-masked store data and its byte mask up by the byte offset
  // across a two-word window; the load side shifts the pair down the same way.
  always_comb begin
    size_mask = 32'd0;
    byte_mask = 4'd0;
    case (size_bytes(funct3))
      3'd1: begin size_mask = 32'h0000_00ff; byte_mask = 4'b0001; end
      3'd2: begin size_mask = 32'h0000_ffff; byte_mask = 4'b0011; end
      3'd4: begin size_mask = 32'hffff_ffff; byte_mask = 4'b1111; end
      default: begin size_mask = 32'd0; byte_mask = 4'd0; end
    endcase

    store_wide = {32'd0, wdata & size_mask} << {off, 3'b000};
    store_lo   = store_wide[31:0];
    store_hi   = store_wide[63:32];
    store_mask = {4'd0, byte_mask} << off;

    merged = 32'({word1, word0} >> {off, 3'b000});
    case (funct3)
      F3_B:    load_data = {{24{merged[7]}}, merged[7:0]};
      F3_BU:   load_data = {24'd0, merged[7:0]};
      F3_H:    load_data = {{16{merged[15]}}, merged[15:0]};
      F3_HU:   load_data = {16'd0, merged[15:0]};
      F3_W:    load_data = merged;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_split_access.sv
// Load/store initiator that turns one CPU access into one or two aligned
// word accesses on a byte-lane memory port, so misaligned H/W accesses work.
module lsu_split_access
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_rdata
);

  localparam logic [DM_ADDRESS-1:0] WORD_STEP = DM_ADDRESS'(4);

  state_t                state;
  logic                  lat_we;
  logic [2:0]            lat_f3;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [31:0]           word0_buf;

  logic [1:0]            off;
  logic [3:0]            span;
  logic                  split;
  logic [DM_ADDRESS-1:0] w0;
  logic [DM_ADDRESS-1:0] w1;
  logic [31:0]           store_lo;
  logic [31:0]           store_hi;
  logic [7:0]            store_mask;
  logic [31:0]           load_data;
  logic [31:0]           merge_word0;
  logic                  wr_raw_en;
  logic [3:0]            wr_raw;

  // Geometry of the latched request: offset, whether it straddles a word,
  // and the two word addresses (the second wraps at the top of memory).
  always_comb begin
    off   = lat_addr[1:0];
    span  = {2'b00, off} + {1'b0, size_bytes(lat_f3)};
    split = (span > 4'd4);
    w0    = {lat_addr[DM_ADDRESS-1:2], 2'b00};
    w1    = w0 + WORD_STEP;
    // In CAPTURE the live read word is word1 when split, otherwise word0.
    merge_word0 = split ? word0_buf : mem_rdata;
  end

  lsu_lane_align u_align (
    .funct3     (lat_f3),
    .off        (off),
    .wdata      (lat_wdata),
    .word0      (merge_word0),
    .word1      (mem_rdata),
    .store_lo   (store_lo),
    .store_hi   (store_hi),
    .store_mask (store_mask),
    .load_data  (load_data)
  );

  // Sequencer: latch the request, issue one or two word accesses, collect
  // read data, then present a single-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_we     <= 1'b0;
      lat_f3     <= 3'd0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      word0_buf  <= 32'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_f3     <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= !is_legal(req_funct3, req_we);
            state      <= is_legal(req_funct3, req_we) ? ST_ISSUE0 : ST_RESP;
          end
        end
        ST_ISSUE0: begin
          if (split)       state <= ST_ISSUE1;
          else if (lat_we) state <= ST_RESP;
          else             state <= ST_CAPTURE;
        end
        ST_ISSUE1: begin
          if (!lat_we) word0_buf <= mem_rdata;
          state <= lat_we ? ST_RESP : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          resp_rdata <= load_data;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port drive per state; write enables are killed by reset so an
  // aborted split store never lands a partial write.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    wr_raw    = 4'd0;
    case (state)
      ST_ISSUE0: begin
        mem_addr = {{(32-DM_ADDRESS){1'b0}}, w0};
        if (lat_we) begin
          mem_wdata = store_lo;
          wr_raw    = store_mask[3:0];
        end
      end
      ST_ISSUE1: begin
        mem_addr = {{(32-DM_ADDRESS){1'b0}}, w1};
        if (lat_we) begin
          mem_wdata = store_hi;
          wr_raw    = store_mask[7:4];
        end
      end
      default: begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        wr_raw    = 4'd0;
      end
    endcase
    wr_raw_en = !reset;
    mem_wr    = wr_raw & {4{wr_raw_en}};
  end

  // Handshake outputs follow directly from the state register.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
  end

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed self-checking bench for lsu_split_access with a byte-lane memory model.
module tb_lsu_split_access;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:511];

  int checks;
  int passes;
  int wr_count;
  int resp_count;

  int          lat;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] i0_addr, i0_wdata, i1_addr, i1_wdata;
  logic [3:0]  i0_wr, i1_wr;
  int          snap_wr, snap_resp;

  lsu_split_access #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane memory: writes lanes on the edge, read data follows one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wr[i]) mem[{mem_addr[8:2], 2'(i)}] <= mem_wdata[8*i +: 8];
    mem_rdata <= {mem[{mem_addr[8:2], 2'd3}], mem[{mem_addr[8:2], 2'd2}],
                  mem[{mem_addr[8:2], 2'd1}], mem[{mem_addr[8:2], 2'd0}]};
  end

  // Event counters used to prove nothing was written/responded when it must not be.
  always @(posedge clk) begin
    if (mem_wr != 4'd0) wr_count <= wr_count + 1;
    if (resp_valid)     resp_count <= resp_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
  endtask

  // Issue one access from IDLE and record the two issue cycles, latency and response.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                               input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    i0_addr = mem_addr; i0_wr = mem_wr; i0_wdata = mem_wdata;
    i1_addr = 32'd0;    i1_wr = 4'd0;   i1_wdata = 32'd0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) begin
        i1_addr = mem_addr; i1_wr = mem_wr; i1_wdata = mem_wdata;
      end
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    @(posedge clk);
    #1;
    checkOutput("resp_pulse_low", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    checks = 0; passes = 0; wr_count = 0; resp_count = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 9'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);
    checkOutput("rst_maddr", mem_addr, 32'd0);
    checkOutput("rst_mwr", 32'(mem_wr), 32'd0);
    reset = 1'b0;

    applyStimulus(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    checkOutput("sw_lat", 32'(lat), 32'd2);
    checkOutput("sw_i0_addr", i0_addr, 32'h010);
    checkOutput("sw_i0_wr", 32'(i0_wr), 32'hF);
    checkOutput("sw_i0_data", i0_wdata, 32'hDEADBEEF);
    checkOutput("sw_rdata", got_rdata, 32'd0);

    applyStimulus(1'b0, 3'b010, 9'h010, 32'd0);
    checkOutput("lw_lat", 32'(lat), 32'd3);
    checkOutput("lw_i0_addr", i0_addr, 32'h010);
    checkOutput("lw_i0_wr", 32'(i0_wr), 32'h0);
    checkOutput("lw_rdata", got_rdata, 32'hDEADBEEF);
    checkOutput("lw_err", 32'(got_err), 32'd0);

    applyStimulus(1'b0, 3'b000, 9'h013, 32'd0);
    checkOutput("lb_rdata", got_rdata, 32'hFFFFFFDE);
    applyStimulus(1'b0, 3'b100, 9'h013, 32'd0);
    checkOutput("lbu_rdata", got_rdata, 32'h000000DE);
    applyStimulus(1'b0, 3'b001, 9'h012, 32'd0);
    checkOutput("lh_lat", 32'(lat), 32'd3);
    checkOutput("lh_rdata", got_rdata, 32'hFFFFDEAD);
    applyStimulus(1'b0, 3'b101, 9'h010, 32'd0);
    checkOutput("lhu_rdata", got_rdata, 32'h0000BEEF);

    applyStimulus(1'b1, 3'b010, 9'h00E, 32'h11223344);
    checkOutput("ssw_lat", 32'(lat), 32'd3);
    checkOutput("ssw_i0_addr", i0_addr, 32'h00C);
    checkOutput("ssw_i0_wr", 32'(i0_wr), 32'hC);
    checkOutput("ssw_i0_data", i0_wdata, 32'h33440000);
    checkOutput("ssw_i1_addr", i1_addr, 32'h010);
    checkOutput("ssw_i1_wr", 32'(i1_wr), 32'h3);
    checkOutput("ssw_i1_data", i1_wdata, 32'h00001122);

    applyStimulus(1'b0, 3'b010, 9'h00E, 32'd0);
    checkOutput("slw_lat", 32'(lat), 32'd4);
    checkOutput("slw_i1_addr", i1_addr, 32'h010);
    checkOutput("slw_rdata", got_rdata, 32'h11223344);
    applyStimulus(1'b0, 3'b010, 9'h010, 32'd0);
    checkOutput("lw10_rdata", got_rdata, 32'hDEAD1122);

    applyStimulus(1'b1, 3'b001, 9'h1FF, 32'h0000ABCD);
    checkOutput("wsh_lat", 32'(lat), 32'd3);
    checkOutput("wsh_i0_addr", i0_addr, 32'h1FC);
    checkOutput("wsh_i0_wr", 32'(i0_wr), 32'h8);
    checkOutput("wsh_i0_data", i0_wdata, 32'hCD000000);
    checkOutput("wsh_i1_addr", i1_addr, 32'h000);
    checkOutput("wsh_i1_wr", 32'(i1_wr), 32'h1);
    checkOutput("wsh_i1_data", i1_wdata, 32'h000000AB);
    applyStimulus(1'b0, 3'b101, 9'h1FF, 32'd0);
    checkOutput("wlhu_lat", 32'(lat), 32'd4);
    checkOutput("wlhu_rdata", got_rdata, 32'h0000ABCD);

    snap_wr = wr_count;
    applyStimulus(1'b0, 3'b011, 9'h010, 32'd0);
    checkOutput("e1_lat", 32'(lat), 32'd1);
    checkOutput("e1_err", 32'(got_err), 32'd1);
    checkOutput("e1_rdata", got_rdata, 32'd0);
    applyStimulus(1'b1, 3'b100, 9'h010, 32'h55555555);
    checkOutput("e2_lat", 32'(lat), 32'd1);
    checkOutput("e2_err", 32'(got_err), 32'd1);
    checkOutput("e2_rdata", got_rdata, 32'd0);
    checkOutput("e_no_write", 32'(wr_count), 32'(snap_wr));

    // Abort a split store while its first word is being issued.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 9'h00E; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("ab_pre_wr", 32'(mem_wr), 32'hC);
    snap_wr = wr_count; snap_resp = resp_count;
    reset = 1'b1;
    #1;
    checkOutput("ab_wr_gated", 32'(mem_wr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("ab_idle", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ab_no_write", 32'(wr_count), 32'(snap_wr));
    checkOutput("ab_no_resp", 32'(resp_count), 32'(snap_resp));
    applyStimulus(1'b0, 3'b010, 9'h010, 32'd0);
    checkOutput("ab_w010", got_rdata, 32'hDEAD1122);
    applyStimulus(1'b0, 3'b001, 9'h00E, 32'd0);
    checkOutput("ab_w00e", got_rdata, 32'h00003344);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
